dac_sample_feeder: RTL

//  Rate-controlled sample source for dac_digital_interface: buffers signed baseband samples from the

---
 rtl/dac_sample_feeder_if.sv | 21 ++
 rtl/dac_sample_feeder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_feeder_if.sv
// Valid/ready sample stream from the modulator into dac_sample_feeder.
// master = sample source, slave = feeder.
interface dac_sample_feeder_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/dac_sample_feeder.sv
// Rate-controlled DAC sample source: FIFO-buffered signed samples, offset-binary output codes.
// Optional build macro DAC_FEEDER_UNDERFLOW_CNT_EN adds a saturating underflow_count_o.
module dac_sample_feeder #(
  parameter int DATA_WIDTH      = 10,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int DIV_WIDTH       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic [DIV_WIDTH-1:0]       rate_div_i,
  dac_sample_feeder_if.slave         s_if,
  output logic [DATA_WIDTH-1:0]      dac_code_o,
  output logic                       dac_update_o,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level_o,
  output logic                       underflow_o,
`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
  output logic [15:0]                underflow_count_o,
`endif
  input  logic                       clear_underflow_i
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_HALF = (FIFO_DEPTH_LOG2+1)'(DEPTH / 2);
  localparam logic [DATA_WIDTH-1:0]    MIDSCALE   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                      state_reg, state_next;
  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [FIFO_DEPTH_LOG2-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [FIFO_DEPTH_LOG2:0]    level_reg, level_next;
  logic [DIV_WIDTH-1:0]        div_reg, div_next;
  logic [DATA_WIDTH-1:0]       code_reg, code_next;
  logic                        update_reg, update_next;
  logic                        ready_reg, ready_next;
  logic                        uf_reg, uf_next;

  logic                        tick;
  logic                        push;
  logic                        pop;
  logic                        tick_empty;
  logic [DATA_WIDTH-1:0]       head_data;

  // Empty check uses the registered level, so a same-cycle push never bypasses to the DAC.
  assign tick       = enable_i && (state_reg == ST_RUN) && (div_reg == '0);
  assign push       = enable_i && s_if.s_valid && ready_reg;
  assign pop        = tick && (level_reg != '0);
  assign tick_empty = tick && (level_reg == '0);
  assign head_data  = mem[rd_ptr_reg];

  always_comb begin
    state_next  = state_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    div_next    = div_reg;
    code_next   = code_reg;
    update_next = 1'b0;
    uf_next     = uf_reg;

    case (state_reg)
      ST_IDLE: begin
        div_next = '0;
        if (enable_i) begin
          state_next = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (level_reg >= LEVEL_HALF) begin
          state_next = ST_RUN;
          div_next   = rate_div_i;
        end
      end
      ST_RUN: begin
        if (div_reg == '0) begin
          div_next = rate_div_i;
        end else begin
          div_next = div_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
      code_next   = {~head_data[DATA_WIDTH-1], head_data[DATA_WIDTH-2:0]};
      update_next = 1'b1;
    end
    if (push && !pop) begin
      level_next = level_reg + 1'b1;
    end else if (pop && !push) begin
      level_next = level_reg - 1'b1;
    end

    if (clear_underflow_i) begin
      uf_next = 1'b0;
    end
    if (tick_empty) begin
      uf_next = 1'b1;
    end

    // Disabled or idle: FIFO flushed, divider parked, output returned to midscale.
    if (!enable_i) begin
      state_next = ST_IDLE;
    end
    if (!enable_i || (state_reg == ST_IDLE)) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      div_next    = '0;
      code_next   = MIDSCALE;
      update_next = (code_reg != MIDSCALE);
    end
  end

  // Registered ready reflects next-cycle state and level, so a full FIFO never accepts.
  assign ready_next = (state_next != ST_IDLE) && (level_next < LEVEL_FULL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      div_reg    <= '0;
      code_reg   <= MIDSCALE;
      update_reg <= 1'b0;
      ready_reg  <= 1'b0;
      uf_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      div_reg    <= div_next;
      code_reg   <= code_next;
      update_reg <= update_next;
      ready_reg  <= ready_next;
      uf_reg     <= uf_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_if.s_data;
    end
  end

`ifdef DAC_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear_underflow_i) begin
      cnt_next = '0;
    end
    if (tick_empty) begin
      if (clear_underflow_i) begin
        cnt_next = 16'd1;
      end else if (cnt_reg != 16'hFFFF) begin
        cnt_next = cnt_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign underflow_count_o = cnt_reg;
`endif

  assign s_if.s_ready = ready_reg;
  assign dac_code_o   = code_reg;
  assign dac_update_o = update_reg;
  assign fifo_level_o = level_reg;
  assign underflow_o  = uf_reg;

endmodule
